// File: rtl/pair_packer.sv
// Packs PAIRS 2-bit symbols LSB-first into one word behind a single-entry valid/ready output register.
// Optional feature: define PAIR_PACKER_PARITY_EN to register even parity of each emitted word on out_par.
module pair_packer #(
  parameter int PAIRS = 4
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [1:0]           sym,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [2*PAIRS-1:0]   out_data,
  output logic [3:0]           out_cnt,
  output logic                 out_par,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int         W       = 2 * PAIRS;
  localparam logic [3:0] PAIRS_C = 4'(PAIRS);

  logic [W-1:0] acc_p0;
  logic [3:0]   cnt_p0;
  logic [W-1:0] merged;
  logic [3:0]   eff_cnt;
  logic         accept;
  logic         slot_free;
  logic         full;
  logic         do_flush;
  logic         load;

  // in_ready depends on cnt only, so a stalled sink never combinationally gates the source
  assign in_ready  = (cnt_p0 < PAIRS_C);
  assign accept    = in_valid && in_ready;
  assign eff_cnt   = cnt_p0 + {3'b000, accept};
  assign slot_free = !out_valid || out_ready;
  assign full      = (eff_cnt == PAIRS_C);
  assign do_flush  = flush && (eff_cnt != 4'd0);
  assign load      = slot_free && (full || do_flush);

  // Accumulator view including this cycle's symbol; slots above cnt are always zero
  always_comb begin
    merged = acc_p0;
    for (int k = 0; k < PAIRS; k++) begin
      if (accept && (cnt_p0 == 4'(k))) begin
        merged[2*k +: 2] = sym;
      end
    end
  end

  // Stage p0 -> p1: accumulator to output register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc_p0    <= '0;
      cnt_p0    <= 4'd0;
      out_data  <= '0;
      out_cnt   <= 4'd0;
      out_valid <= 1'b0;
    end else if (load) begin
      acc_p0    <= '0;
      cnt_p0    <= 4'd0;
      out_data  <= merged;
      out_cnt   <= eff_cnt;
      out_valid <= 1'b1;
    end else begin
      acc_p0 <= merged;
      cnt_p0 <= eff_cnt;
      if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef PAIR_PACKER_PARITY_EN
  function automatic logic parity_of(input logic [W-1:0] d);
    return ^d;
  endfunction

  logic par_p1;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      par_p1 <= 1'b0;
    end else if (load) begin
      par_p1 <= parity_of(merged);
    end
  end

  assign out_par = par_p1;
`else
  assign out_par = 1'b0;
`endif

endmodule

// File: tb/tb_pair_packer.sv
// Self-checking bench for pair_packer: directed scenarios plus randomized traffic against a symbol-stream scoreboard.
module tb_pair_packer;

  localparam int PAIRS = 4;
  localparam int W     = 2 * PAIRS;

  logic         clk = 1'b0;
  logic         rst_b = 1'b0;
  logic [1:0]   sym = 2'b00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         flush = 1'b0;
  logic [W-1:0] out_data;
  logic [3:0]   out_cnt;
  logic         out_par;
  logic         out_valid;
  logic         out_ready = 1'b0;

  pair_packer #(.PAIRS(PAIRS)) dut (
    .clk(clk), .rst_b(rst_b), .sym(sym), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_data(out_data), .out_cnt(out_cnt), .out_par(out_par),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_par(input logic [W-1:0] d);
`ifdef PAIR_PACKER_PARITY_EN
    return ^d;
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard: every accepted symbol, in order; each emitted word must consume the front of the stream
  logic [1:0]   sq[$];
  int           words = 0;
  bit           expect_full = 0;
  logic         pv = 1'b0, pr = 1'b0;
  logic [W-1:0] pd;
  logic [3:0]   pc;
  logic         pp;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_b) begin
        sq.delete();
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("hold_valid", {31'd0, out_valid}, 32'd1);
          chk("hold_data", {24'd0, out_data}, {24'd0, pd});
          chk("hold_cnt", {28'd0, out_cnt}, {28'd0, pc});
          chk("hold_par", {31'd0, out_par}, {31'd0, pp});
        end
        if (out_valid && out_ready) begin
          logic [W-1:0] e;
          e = '0;
          words++;
          chk("cnt_range", {31'd0, (out_cnt >= 4'd1 && out_cnt <= 4'(PAIRS))}, 32'd1);
          if (expect_full) chk("full_cnt", {28'd0, out_cnt}, PAIRS);
          for (int k = 0; k < PAIRS; k++) begin
            if (k < int'(out_cnt)) begin
              if (sq.size() == 0) chk("stream_underflow", 32'd1, 32'd0);
              else e[2*k +: 2] = sq.pop_front();
            end
          end
          chk("word_data", {24'd0, out_data}, {24'd0, e});
          chk("word_par", {31'd0, out_par}, {31'd0, exp_par(e)});
        end
        if (in_valid && in_ready) sq.push_back(sym);
        pv = out_valid; pr = out_ready; pd = out_data; pc = out_cnt; pp = out_par;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s);
    sym = s;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  logic [1:0] sweep[10];
  int w0;

  initial begin
    // Reset state
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_cnt", {28'd0, out_cnt}, 32'd0);
    chk("rst_par", {31'd0, out_par}, 32'd0);
    @(posedge clk); #1 rst_b = 1'b1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic pack
    out_ready = 1'b1;
    in_valid = 1'b1;
    sym = 2'b01; cyc();
    sym = 2'b10; cyc();
    sym = 2'b11; cyc();
    sym = 2'b00; cyc();
    in_valid = 1'b0;
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_data", {24'd0, out_data}, 32'h39);
    chk("basic_cnt", {28'd0, out_cnt}, 32'd4);
    chk("basic_par", {31'd0, out_par}, 32'd0);
    cyc();
    chk("basic_one_cycle", {31'd0, out_valid}, 32'd0);

    // Back-pressure
    out_ready = 1'b0;
    sym = 2'b11;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd1);
      cyc();
    end
    in_valid = 1'b0;
    chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_data", {24'd0, out_data}, 32'hFF);
    cyc(); cyc();
    chk("bp_still_stalled", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    w0 = words;
    cyc();
    chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_second_data", {24'd0, out_data}, 32'hFF);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    cyc();
    chk("bp_words", words - w0, 32'd2);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush of a partial word
    send(2'b10);
    send(2'b01);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd1);
    chk("flush_data", {24'd0, out_data}, 32'h06);
    chk("flush_cnt", {28'd0, out_cnt}, 32'd2);
    cyc();
    w0 = words;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("flush_empty_valid", {31'd0, out_valid}, 32'd0);
    end
    flush = 1'b0;
    cyc();
    chk("flush_empty_words", words - w0, 32'd0);

    // Flush including the same-cycle symbol
    send(2'b11);
    sym = 2'b01; in_valid = 1'b1; flush = 1'b1;
    cyc();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_same_valid", {31'd0, out_valid}, 32'd1);
    chk("flush_same_data", {24'd0, out_data}, 32'h07);
    chk("flush_same_cnt", {28'd0, out_cnt}, 32'd2);
    cyc();

    // Sweep of a 10-symbol stream with a flushed tail
    for (int i = 0; i < 10; i++) begin
      logic [3:0] v;
      v = 4'(i);
      sweep[i] = v[1:0] ^ v[3:2];
    end
    w0 = words;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sym = sweep[i];
      cyc();
    end
    in_valid = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("sweep_tail_cnt", {28'd0, out_cnt}, 32'd2);
    chk("sweep_tail_data", {24'd0, out_data}, {28'd0, sweep[9], sweep[8]});
    cyc();
    chk("sweep_words", words - w0, 32'd3);

    // Reset mid-word with a pending output word
    out_ready = 1'b0;
    in_valid = 1'b1;
    sym = 2'b10;
    repeat (6) cyc();
    in_valid = 1'b0;
    chk("mid_pending", {31'd0, out_valid}, 32'd1);
    #3 rst_b = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, out_data}, 32'd0);
    chk("mid_rst_cnt", {28'd0, out_cnt}, 32'd0);
    chk("mid_rst_par", {31'd0, out_par}, 32'd0);
    @(posedge clk); #1 rst_b = 1'b1;
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    sym = 2'b01; cyc();
    sym = 2'b11; cyc();
    sym = 2'b01; cyc();
    sym = 2'b11; cyc();
    in_valid = 1'b0;
    chk("mid_fresh_data", {24'd0, out_data}, 32'hDD);
    chk("mid_fresh_cnt", {28'd0, out_cnt}, 32'd4);
    cyc();

    // Randomized traffic with random back-pressure
    expect_full = 1;
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      sym       = 2'($urandom);
      out_ready = ($urandom_range(2) != 0);
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cyc();
    expect_full = 0;
    flush = 1'b1;
    repeat (3) cyc();
    flush = 1'b0;
    repeat (3) cyc();
    chk("rand_drained_stream", sq.size(), 32'd0);
    chk("rand_drained_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
